// File: rtl/ast_skid_pipe.sv
// ---------------------------------------------------------------------------
// ast_skid_pipe
//
// Avalon-ST pipeline slice built from STAGES full-throughput skid-buffer
// stages. Every stage registers data, valid and ready. There is therefore no
// combinational path from src_ready_i to sink_ready_o, and the slice still
// moves one beat per cycle under any backpressure pattern.
//
// Each stage holds a main register (M, flag mv) that drives its output, and
// a skid register (S, flag sv). S catches the one beat that can arrive while
// the stage is stalled, because the upstream side only sees the registered
// ready one cycle later.
//
// Parameters:
//   DWIDTH         data width, a multiple of BITS_PER_SYMB
//   BITS_PER_SYMB  bits per symbol, which sets the empty width
//   CHANNEL_WIDTH  channel width, >= 1
//   STAGES         number of skid stages, 1..8
//   EMPTY_WIDTH    derived as max(1, clog2(DWIDTH/BITS_PER_SYMB))
//
// Ports:
//   clk_i, rst_n_i         clock and asynchronous active-low reset
//   sink_*                 upstream beat; sink_ready_o is registered
//                          (readyLatency 0)
//   src_*                  downstream beat; src_ready_i comes from downstream
//   clr_err_i              clears the sticky protocol error flags
//   err_o[2:0]             sticky flags: [0] SOP inside a packet,
//                          [1] non-SOP beat outside a packet,
//                          [2] non-zero empty without EOP
//
// Optional feature macro: AST_PROTO_CHECK_EN
//   Defined:   a packet-framing checker watches the sink and drives err_o.
//   Undefined: err_o is tied to 0 and clr_err_i is ignored.
// ---------------------------------------------------------------------------
module ast_skid_pipe #(
  parameter int  DWIDTH        = 64,
  parameter int  BITS_PER_SYMB = 8,
  parameter int  CHANNEL_WIDTH = 1,
  parameter int  STAGES        = 2,
  localparam int SYMBOLS       = DWIDTH / BITS_PER_SYMB,
  localparam int EMPTY_WIDTH   = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [DWIDTH-1:0]        sink_data_i,
  input  logic                     sink_valid_i,
  input  logic                     sink_startofpacket_i,
  input  logic                     sink_endofpacket_i,
  input  logic [EMPTY_WIDTH-1:0]   sink_empty_i,
  input  logic [CHANNEL_WIDTH-1:0] sink_channel_i,
  output logic                     sink_ready_o,
  output logic [DWIDTH-1:0]        src_data_o,
  output logic                     src_valid_o,
  output logic                     src_startofpacket_o,
  output logic                     src_endofpacket_o,
  output logic [EMPTY_WIDTH-1:0]   src_empty_o,
  output logic [CHANNEL_WIDTH-1:0] src_channel_o,
  input  logic                     src_ready_i,
  input  logic                     clr_err_i,
  output logic [2:0]               err_o
);

  // Elaboration-time parameter checks
  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $error("ast_skid_pipe: STAGES=%0d is outside 1..8", STAGES);
  end
  if ((DWIDTH % BITS_PER_SYMB) != 0) begin : g_bad_dwidth
    $error("ast_skid_pipe: DWIDTH=%0d is not a multiple of BITS_PER_SYMB=%0d",
           DWIDTH, BITS_PER_SYMB);
  end

  // A beat travels as one packed word: {data, sop, eop, empty, channel}
  localparam int BW = DWIDTH + 2 + EMPTY_WIDTH + CHANNEL_WIDTH;

  logic [BW-1:0]     m_q [STAGES];
  logic [BW-1:0]     s_q [STAGES];
  logic [STAGES-1:0] mv_q;
  logic [STAGES-1:0] sv_q;
  logic [STAGES-1:0] rdy_q;

  // Chains joining the stages. Index k is the input side of stage k, and
  // index k+1 is its output side. Index 0 is the block sink and index
  // STAGES is the block source.
  logic [BW-1:0]     beat_chain [STAGES+1];
  logic [STAGES:0]   valid_chain;
  logic [STAGES:0]   ready_chain;

  logic [STAGES-1:0] mv_d;
  logic [STAGES-1:0] sv_d;
  logic [STAGES-1:0] load_m;
  logic [STAGES-1:0] load_s;
  logic [STAGES-1:0] m_from_s;

  assign valid_chain = {mv_q, sink_valid_i};
  assign ready_chain = {src_ready_i, rdy_q};

  always_comb begin
    beat_chain[0] = {sink_data_i, sink_startofpacket_i, sink_endofpacket_i,
                     sink_empty_i, sink_channel_i};
    for (int k = 0; k < STAGES; k++) begin
      beat_chain[k+1] = m_q[k];
    end
  end

  // Per-stage next state. The stage's in_ready (rdy_q[k]) is low whenever S
  // is occupied, so a skid unload and an accept never happen together.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    mv_d     = mv_q;
    sv_d     = sv_q;
    load_m   = '0;
    load_s   = '0;
    m_from_s = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (ready_chain[k+1] && sv_q[k]) begin
        // Downstream takes M; the skid beat moves up into M.
        load_m[k]   = 1'b1;
        m_from_s[k] = 1'b1;
        sv_d[k]     = 1'b0;
      end else if (valid_chain[k] && ready_chain[k]) begin
        if (!mv_q[k] || ready_chain[k+1]) begin
          // M is empty or draining this cycle: the new beat replaces it.
          load_m[k] = 1'b1;
          mv_d[k]   = 1'b1;
        end else begin
          // M is held by backpressure: park the beat in S.
          load_s[k] = 1'b1;
          sv_d[k]   = 1'b1;
        end
      end else if (ready_chain[k+1] && mv_q[k]) begin
        mv_d[k] = 1'b0;
      end
    end
  end

  // Control flags. rdy_q is reset to 0 so that sink_ready_o stays low
  // during reset and rises on the first edge after release.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: state registers use non-blocking assignments so that every
    // stage samples its neighbour's pre-edge value, as real flops do.
    if (!rst_n_i) begin
      mv_q  <= '0;
      sv_q  <= '0;
      rdy_q <= '0;
    end else begin
      mv_q  <= mv_d;
      sv_q  <= sv_d;
      rdy_q <= ~sv_d;
    end
  end

  // Beat payload registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: the payload registers are reset as well, so that src_* fields
    // read as zero after reset rather than as stale data.
    if (!rst_n_i) begin
      for (int k = 0; k < STAGES; k++) begin
        m_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load_m[k]) m_q[k] <= m_from_s[k] ? s_q[k] : beat_chain[k];
        if (load_s[k]) s_q[k] <= beat_chain[k];
      end
    end
  end

  assign sink_ready_o = ready_chain[0];
  assign src_valid_o  = valid_chain[STAGES];
  assign {src_data_o, src_startofpacket_o, src_endofpacket_o,
          src_empty_o, src_channel_o} = beat_chain[STAGES];

`ifdef AST_PROTO_CHECK_EN
  // Packet-framing checker on the sink side. It only observes beats and
  // never alters them.
  logic       in_pkt_q;
  logic       sink_acc;
  logic [2:0] err_q;
  logic [2:0] err_new;

  assign sink_acc = sink_valid_i & ready_chain[0];

  always_comb begin
    err_new = '0;
    if (sink_acc) begin
      err_new[0] = sink_startofpacket_i & in_pkt_q;
      err_new[1] = ~sink_startofpacket_i & ~in_pkt_q;
      err_new[2] = (sink_empty_i != '0) & ~sink_endofpacket_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      in_pkt_q <= 1'b0;
      err_q    <= '0;
    end else begin
      // EOP ends the packet, so a single-beat SOP+EOP packet leaves in_pkt clear.
      if (sink_acc) begin
        if (sink_endofpacket_i)        in_pkt_q <= 1'b0;
        else if (sink_startofpacket_i) in_pkt_q <= 1'b1;
      end
      // A new error on the clearing cycle still sets its flag.
      err_q <= (clr_err_i ? 3'b000 : err_q) | err_new;
    end
  end

  assign err_o = err_q;
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err_i;
  assign err_o          = 3'b000;
`endif

endmodule

// File: doc/ast_skid_pipe.md
Name: ast_skid_pipe

Overview:
- Parametrised Avalon-ST pipeline slice: a chain of STAGES full-throughput skid-buffer stages between a sink and a source.
- Both directions are fully registered, including ready, with no combinational path src_ready_i -> sink_ready_o.
- Sustains 1 beat/cycle under arbitrary backpressure with no beat loss or duplication.
- Replaces naive one-flop boundary registering at packet-block wrappers, which drops beats when ready is registered.

Parameters:
- DWIDTH, 64, data bus width in bits; must be a multiple of BITS_PER_SYMB.
- BITS_PER_SYMB, 8, bits per symbol; sets the empty width.
- CHANNEL_WIDTH, 1, channel field width, >=1.
- STAGES, 2, number of skid stages, 1..8; elaboration error outside this range.
- EMPTY_WIDTH, derived: max(1, $clog2(DWIDTH/BITS_PER_SYMB)).

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- sink_data_i  in  DWIDTH  input data
- sink_valid_i  in  1  input beat valid
- sink_startofpacket_i  in  1  SOP
- sink_endofpacket_i  in  1  EOP
- sink_empty_i  in  EMPTY_WIDTH  empty symbols; meaningful on EOP only
- sink_channel_i  in  CHANNEL_WIDTH  channel
- sink_ready_o  out  1  registered ready; readyLatency 0
- src_data_o, src_startofpacket_o, src_endofpacket_o, src_empty_o, src_channel_o  out  widths as on the sink  output beat fields
- src_valid_o  out  1  output beat valid
- src_ready_i  in  1  downstream ready
- clr_err_i  in  1  clears err_o; protocol checker only
- err_o  out  3  sticky protocol error flags

Behaviour:
- One clock; reset is asynchronous and active-low.
- Beat transfer: a beat moves on a cycle where valid & ready are both high at that interface. Beat = {data, sop, eop, empty, channel}.
- Stage structure: each stage has a main register M with valid flag mv and a skid register S with valid flag sv. Stage k's source feeds stage k+1's sink; stage 0 is the block sink, stage STAGES-1 is the block source.
- Stage ready: in_ready is a register, equal to ~sv as of the previous edge. It is never derived combinationally from out_ready.
- Stage update rules, per edge:
  - Input accepted and M empty, or M draining this cycle with S empty: beat goes to M.
  - Input accepted while M is held, i.e. mv & ~out_ready: beat goes to S, sv<=1.
  - out_ready & sv: M<=S, sv<=0. Any beat accepted on the same cycle is impossible, because in_ready was 0.
  - out_ready & mv & ~sv & no input: mv<=0.
- Simultaneous accept and drain with S empty: M replaced, mv stays 1, full throughput.
- Latency: a beat accepted at edge n is visible on src_* after edge n+STAGES-1; STAGES cycles sink to source, with no stalls.
- Capacity: 2*STAGES beats in flight. When downstream stalls, sink_ready_o falls within STAGES+1 cycles; beats already accepted are never lost.
- Ordering: strict FIFO. Fields are never altered.
- Reset values:
  - All mv/sv = 0, src_valid_o = 0.
  - sink_ready_o = 0 while rst_n_i is low; it rises on the first edge after release.
  - All data/sop/eop/empty/channel registers = 0.
  - err_o = 0.
- Reset mid-operation: all in-flight beats are discarded immediately and asynchronously; outputs take their reset values.
- src_valid_o never deasserts while src_ready_i is low once asserted, which is Avalon-ST stable-data compliant. src_* fields are held stable during a stall.

Optional Feature:
- Macro: AST_PROTO_CHECK_EN.
- When defined, a checker on the sink interface tracks in_pkt. It sets in_pkt on an accepted SOP and clears it on an accepted EOP; a beat with both sets nothing.
- Error flags:
  - err_o[0]: accepted SOP while in_pkt (missing EOP).
  - err_o[1]: accepted non-SOP beat while ~in_pkt (missing SOP).
  - err_o[2]: accepted beat with sink_empty_i != 0 and no EOP.
- Flags are sticky. clr_err_i clears them on the next edge; a new error on the same cycle as clr_err_i wins (flag set).
- Beats are forwarded unchanged regardless of errors.
- When not defined: err_o is tied to 0, clr_err_i is ignored, and the port list is unchanged.

Test Plan:
- STAGES=2, src_ready_i=1, continuous 16-beat packet with data 0..15 -> src_valid_o first high 2 cycles after the first accept; 16 consecutive beats 0..15 out; sink_ready_o never low.
- STAGES=3, src_ready_i low for 10 cycles mid-stream -> sink_ready_o falls within 4 cycles; exactly 6 beats buffered; on release all beats out in order, none dropped or duplicated.
- Random valid/ready at 50% each, STAGES=1..8, 2000 beats -> scoreboard exact match; src fields stable while src_valid_o & ~src_ready_i.
- rst_n_i pulsed low asynchronously mid-packet with 3 beats in flight -> src_valid_o=0 and sink_ready_o=0 immediately; sink_ready_o=1 one edge after release; no stale beats emitted.
- With AST_PROTO_CHECK_EN: SOP, data, SOP -> err_o=3'b001. Then pulse clr_err_i -> 000. Then a beat with empty=3 and no EOP -> 3'b100.
- Without AST_PROTO_CHECK_EN: same stimulus -> err_o stays 0.
